// File: rtl/dma_host_initiator.sv
// DMA host initiator: takes one copy command, range-checks it against the
// DMA memory map, programs SRC/DST/SIZE/CSR over a simple req/ack bus, then
// polls CSR until DONE, ERROR or the poll limit and returns a status pulse.
module dma_host_initiator #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MEM_SIZE_WORD = 'h4000,
  parameter int POLL_GAP      = 4,
  parameter int POLL_LIMIT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [DATA_WIDTH-1:0] cmd_size,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic                  busy,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack
);

  localparam int SUM_W = ADDR_WIDTH + 2;
  localparam int PW    = $clog2(POLL_LIMIT + 1);
  localparam int GW    = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

  localparam logic [SUM_W-1:0]      MEM_END   = SUM_W'(MEM_SIZE_WORD * 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CSR  = ADDR_WIDTH'('h8000);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SIZE = ADDR_WIDTH'('h8002);
  localparam logic [ADDR_WIDTH-1:0] ADDR_DST  = ADDR_WIDTH'('h8004);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SRC  = ADDR_WIDTH'('h8006);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_DMA_ERR = 2'd1;
  localparam logic [1:0] ST_BAD_ARG = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WR_SRC, S_WR_DST, S_WR_SIZE, S_WR_GO,
    S_POLL_RD, S_POLL_WAIT, S_RESP
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] src_reg, src_next, dst_reg, dst_next;
  logic [DATA_WIDTH-1:0] size_reg, size_next;
  logic [PW-1:0]         poll_cnt_reg, poll_cnt_next, poll_cnt_inc;
  logic [GW-1:0]         gap_cnt_reg, gap_cnt_next;
  logic                  wr_done_reg, wr_done_next;
  logic [1:0]            status_reg, status_next;
  logic                  bus_req_reg, bus_req_next, bus_we_reg, bus_we_next;
  logic [ADDR_WIDTH-1:0] bus_addr_reg, bus_addr_next;
  logic [DATA_WIDTH-1:0] bus_wdata_reg, bus_wdata_next;
  logic                  launch;
  logic [SUM_W-1:0]      size_x2, src_end, dst_end;
  logic                  bad_arg;
  logic                  unused_rdata;

  // Only ERROR (bit3) and DONE (bit2) of CSR steer the sequence.
  assign unused_rdata = ^{bus_rdata[DATA_WIDTH-1:4], bus_rdata[1:0]};

  assign cmd_ready  = (state_reg == S_IDLE) && !rst;
  assign busy       = (state_reg != S_IDLE);
  assign rsp_valid  = (state_reg == S_RESP);
  assign rsp_status = status_reg;
  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_wdata  = bus_wdata_reg;

  // Range check on the captured command; sums are wide enough to never wrap.
  always_comb begin
    size_x2 = SUM_W'(size_reg) << 1;
    src_end = SUM_W'(src_reg) + size_x2;
    dst_end = SUM_W'(dst_reg) + size_x2;
    bad_arg = (size_reg == '0) || (32'(size_reg) > 32'(MEM_SIZE_WORD)) ||
              src_reg[0] || dst_reg[0] || (src_end > MEM_END) || (dst_end > MEM_END);
  end

  // Next-state, bus request sequencing and response status.
  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    size_next      = size_reg;
    poll_cnt_next  = poll_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    wr_done_next   = wr_done_reg;
    status_next    = status_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    poll_cnt_inc   = poll_cnt_reg + PW'(1);
    launch         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          src_next      = cmd_src;
          dst_next      = cmd_dst;
          size_next     = cmd_size;
          poll_cnt_next = '0;
          state_next    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_arg) begin
          status_next = ST_BAD_ARG;
          state_next  = S_RESP;
        end else begin
          state_next = S_WR_SRC;
          launch     = 1'b1;
        end
      end
      // Writes: request until ack, then one idle cycle before the next request.
      S_WR_SRC, S_WR_DST, S_WR_SIZE, S_WR_GO: begin
        if (bus_req_reg && bus_ack) begin
          bus_req_next = 1'b0;
          wr_done_next = 1'b1;
        end else if (wr_done_reg) begin
          wr_done_next = 1'b0;
          launch       = 1'b1;
          case (state_reg)
            S_WR_SRC:  state_next = S_WR_DST;
            S_WR_DST:  state_next = S_WR_SIZE;
            S_WR_SIZE: state_next = S_WR_GO;
            default:   state_next = S_POLL_RD;
          endcase
        end
      end
      S_POLL_RD: begin
        if (bus_req_reg && bus_ack) begin
          bus_req_next  = 1'b0;
          poll_cnt_next = poll_cnt_inc;
          if (bus_rdata[3]) begin
            status_next = ST_DMA_ERR;
            state_next  = S_RESP;
          end else if (bus_rdata[2]) begin
            status_next = ST_OK;
            state_next  = S_RESP;
          end else if (poll_cnt_inc == PW'(POLL_LIMIT)) begin
            status_next = ST_TIMEOUT;
            state_next  = S_RESP;
          end else begin
            gap_cnt_next = '0;
            state_next   = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: begin
        if (gap_cnt_reg == GW'(POLL_GAP)) begin
          state_next = S_POLL_RD;
          launch     = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + GW'(1);
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // A new request is raised in the first cycle of the bus state being entered.
    if (launch) begin
      bus_req_next = 1'b1;
      bus_we_next  = 1'b1;
      case (state_next)
        S_WR_SRC: begin
          bus_addr_next  = ADDR_SRC;
          bus_wdata_next = DATA_WIDTH'(src_reg);
        end
        S_WR_DST: begin
          bus_addr_next  = ADDR_DST;
          bus_wdata_next = DATA_WIDTH'(dst_reg);
        end
        S_WR_SIZE: begin
          bus_addr_next  = ADDR_SIZE;
          bus_wdata_next = size_reg;
        end
        S_WR_GO: begin
          bus_addr_next  = ADDR_CSR;
          bus_wdata_next = DATA_WIDTH'(1);
        end
        default: begin
          bus_we_next    = 1'b0;
          bus_addr_next  = ADDR_CSR;
          bus_wdata_next = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      size_reg      <= '0;
      poll_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      wr_done_reg   <= 1'b0;
      status_reg    <= ST_OK;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      size_reg      <= size_next;
      poll_cnt_reg  <= poll_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      wr_done_reg   <= wr_done_next;
      status_reg    <= status_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
    end
  end

endmodule

// File: tb/tb_dma_host_initiator.sv
// Directed testbench for dma_host_initiator with a behavioural bus responder.
module tb_dma_host_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_src, cmd_dst, cmd_size;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic        busy, bus_req, bus_we;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  int total = 0;
  int bad   = 0;

  // Responder configuration (written by tests) and log (written by responder).
  logic [15:0] csr_tab [0:7];
  int          csr_base     = 0;
  logic [15:0] stall_addr   = 16'hFFFF;
  int          stall_delay  = 1;
  int          spur_req_cnt = 0;
  int          spur_done_cnt = 0;
  int          reads_total  = 0;
  int          proto_err    = 0;
  bit          log_we [$];
  logic [15:0] log_addr [$];
  logic [15:0] log_wdata [$];
  time         log_req_t [$];
  time         log_ack_t [$];
  time         t_cmd;

  always #5 clk = ~clk;

  dma_host_initiator #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_SIZE_WORD('h4000),
    .POLL_GAP(4), .POLL_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .busy(busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  // Bus responder: acks after a configurable delay, checks request stability.
  initial begin : responder
    int seen, dly, idx;
    bit acked_prev;
    logic [15:0] a0, d0;
    logic w0;
    time req_t;
    bus_ack = 1'b0; bus_rdata = '0; seen = 0; acked_prev = 0;
    a0 = '0; d0 = '0; w0 = 1'b0; req_t = 0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (acked_prev && bus_req) proto_err++;
      acked_prev = 0;
      if (bus_req) begin
        if (seen == 0) begin
          req_t = $time; a0 = bus_addr; d0 = bus_wdata; w0 = bus_we;
        end else if (bus_addr !== a0 || bus_wdata !== d0 || bus_we !== w0) begin
          proto_err++;
        end
        dly = (bus_addr == stall_addr) ? stall_delay : 1;
        if (seen >= dly) begin
          bus_ack = 1'b1;
          if (!bus_we) begin
            idx = reads_total - csr_base;
            if (idx > 7) idx = 7;
            bus_rdata = csr_tab[idx];
            reads_total++;
          end else begin
            bus_rdata = '0;
          end
          log_we.push_back(bus_we); log_addr.push_back(bus_addr);
          log_wdata.push_back(bus_wdata); log_req_t.push_back(req_t);
          log_ack_t.push_back($time);
          $display("txn %s addr=%h data=%h t=%0t", bus_we ? "WR" : "RD", bus_addr,
                   bus_we ? bus_wdata : bus_rdata, $time);
          acked_prev = 1; seen = 0;
        end else begin
          seen++;
        end
      end else begin
        seen = 0;
        if (spur_done_cnt != spur_req_cnt) begin
          bus_ack = 1'b1;
          spur_done_cnt++;
        end
      end
    end
  end

  task automatic set_csr(input logic [15:0] v0, v1, v2, vrest);
    csr_tab[0] = v0; csr_tab[1] = v1; csr_tab[2] = v2;
    for (int i = 3; i < 8; i++) csr_tab[i] = vrest;
    csr_base = reads_total;
  endtask

  task automatic send_cmd(input logic [15:0] s, d, z, input bit hold);
    @(negedge clk);
    cmd_src = s; cmd_dst = d; cmd_size = z; cmd_valid = 1'b1; t_cmd = $time;
    @(negedge clk);
    if (!hold) begin
      cmd_valid = 1'b0; cmd_src = 16'hDEAD; cmd_dst = 16'hBEEF; cmd_size = 16'hCAFE;
    end
  endtask

  task automatic wait_rsp(input int budget, output bit got, output logic [1:0] st,
                          output bit rb);
    got = 0; st = '0; rb = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy && cmd_ready) rb = 1;
      if (rsp_valid) begin got = 1; st = rsp_status; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_status !== 2'd0) begin bad++;
      $display("FAIL reset_rsp busy=%b rsp_valid=%b rsp_status=%0d exp=0/0/0", busy, rsp_valid, rsp_status); end
    total++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin bad++;
      $display("FAIL reset_bus req=%b we=%b addr=%h wdata=%h exp=0", bus_req, bus_we, bus_addr, bus_wdata); end
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_normal();
    bit got, rb; logic [1:0] st; int base, lat;
    logic [15:0] ea [5]; logic [15:0] ed [4];
    ea = '{16'h8006, 16'h8004, 16'h8002, 16'h8000, 16'h8000};
    ed = '{16'h0000, 16'h1000, 16'h0010, 16'h0001};
    set_csr(16'h0004, 16'h0004, 16'h0004, 16'h0004);
    base = log_addr.size();
    send_cmd(16'h0000, 16'h1000, 16'h0010, 0);
    wait_rsp(60, got, st, rb);
    lat = int'(($time - t_cmd) / 10);
    total++; if (!got) begin bad++; $display("FAIL normal_rsp no response within 60 cycles"); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL normal_status got=%0d exp=0", st); end
    total++; if (lat != 16) begin bad++; $display("FAIL normal_latency got=%0d exp=16", lat); end
    total++; if (log_addr.size() - base != 5) begin bad++;
      $display("FAIL normal_txn_count got=%0d exp=5", log_addr.size() - base); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (log_addr[base+i] !== ea[i] || log_we[base+i] !== (i < 4)) begin bad++;
          $display("FAIL normal_txn%0d addr=%h we=%b exp addr=%h we=%b", i, log_addr[base+i], log_we[base+i], ea[i], i < 4); end
        if (i < 4) begin
          total++; if (log_wdata[base+i] !== ed[i]) begin bad++;
            $display("FAIL normal_wdata%0d got=%h exp=%h", i, log_wdata[base+i], ed[i]); end
        end
      end
      total++; if (int'(log_req_t[base] - t_cmd) != 20) begin bad++;
        $display("FAIL normal_first_req got=%0d exp=20", int'(log_req_t[base] - t_cmd)); end
      total++; if (int'(log_req_t[base+1] - log_req_t[base]) != 30) begin bad++;
        $display("FAIL normal_write_spacing got=%0d exp=30", int'(log_req_t[base+1] - log_req_t[base])); end
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++;
      $display("FAIL normal_after_rsp rsp_valid=%b busy=%b cmd_ready=%b exp=0/0/1", rsp_valid, busy, cmd_ready); end
  endtask

  task automatic test_error_priority();
    bit got, rb; logic [1:0] st; int base, r0;
    set_csr(16'h0002, 16'h0002, 16'h000C, 16'h0004);
    base = log_addr.size(); r0 = reads_total;
    send_cmd(16'h0100, 16'h0200, 16'h0008, 0);
    wait_rsp(100, got, st, rb);
    total++; if (!got || st !== 2'd1) begin bad++; $display("FAIL err_status got=%0d valid=%b exp=1", st, got); end
    total++; if (reads_total - r0 != 3) begin bad++; $display("FAIL err_poll_count got=%0d exp=3", reads_total - r0); end
    else if (log_addr.size() - base == 7) begin
      total++; if (int'(log_req_t[base+5] - log_req_t[base+4]) != 70 ||
                   int'(log_req_t[base+6] - log_req_t[base+5]) != 70) begin bad++;
        $display("FAIL err_poll_spacing got=%0d,%0d exp=70,70", int'(log_req_t[base+5] - log_req_t[base+4]),
                 int'(log_req_t[base+6] - log_req_t[base+5])); end
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || rsp_status !== 2'd1) begin bad++;
      $display("FAIL err_status_hold rsp_valid=%b status=%0d exp=0/1", rsp_valid, rsp_status); end
  endtask

  task automatic test_bad_args();
    bit got, rb; logic [1:0] st; int base, lat;
    logic [15:0] vs [4]; logic [15:0] vd [4]; logic [15:0] vz [4];
    vs = '{16'h0000, 16'h0000, 16'h0001, 16'h0000};
    vd = '{16'h1000, 16'h1000, 16'h0000, 16'h7FF0};
    vz = '{16'h0000, 16'h4001, 16'h0001, 16'h0010};
    set_csr(16'h0004, 16'h0004, 16'h0004, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      base = log_addr.size();
      send_cmd(vs[i], vd[i], vz[i], 0);
      wait_rsp(10, got, st, rb);
      lat = int'(($time - t_cmd) / 10);
      total++; if (!got || st !== 2'd2 || lat != 2) begin bad++;
        $display("FAIL bad_arg%0d status=%0d valid=%b lat=%0d exp=2/1/2", i, st, got, lat); end
      total++; if (log_addr.size() != base) begin bad++;
        $display("FAIL bad_arg%0d_bus got=%0d txns exp=0", i, log_addr.size() - base); end
    end
    base = log_addr.size();
    send_cmd(16'h0000, 16'h7FE0, 16'h0010, 0);
    wait_rsp(60, got, st, rb);
    total++; if (!got || st !== 2'd0) begin bad++; $display("FAIL boundary_status got=%0d valid=%b exp=0", st, got); end
    total++; if (log_addr.size() - base != 5 || log_wdata[base+1] !== 16'h7FE0) begin bad++;
      $display("FAIL boundary_txns count=%0d exp=5 dst_wdata exp=7fe0", log_addr.size() - base); end
  endtask

  task automatic test_timeout();
    bit got, rb; logic [1:0] st; int r0;
    set_csr(16'h0002, 16'h0002, 16'h0002, 16'h0002);
    r0 = reads_total;
    send_cmd(16'h0100, 16'h0200, 16'h0001, 0);
    wait_rsp(100, got, st, rb);
    total++; if (!got || st !== 2'd3) begin bad++; $display("FAIL timeout_status got=%0d valid=%b exp=3", st, got); end
    repeat (20) @(negedge clk);
    total++; if (reads_total - r0 != 3 || busy !== 1'b0) begin bad++;
      $display("FAIL timeout_reads got=%0d busy=%b exp=3/0", reads_total - r0, busy); end
  endtask

  task automatic test_stall_hold();
    bit got, rb; logic [1:0] st; int base, pe0, lat;
    set_csr(16'h0004, 16'h0004, 16'h0004, 16'h0004);
    stall_addr = 16'h8004; stall_delay = 7;
    base = log_addr.size(); pe0 = proto_err;
    send_cmd(16'h0040, 16'h2000, 16'h0020, 1);
    wait_rsp(80, got, st, rb);
    cmd_valid = 1'b0;
    lat = int'(($time - t_cmd) / 10);
    stall_addr = 16'hFFFF; stall_delay = 1;
    total++; if (!got || st !== 2'd0 || lat != 22) begin bad++;
      $display("FAIL stall_rsp status=%0d valid=%b lat=%0d exp=0/1/22", st, got, lat); end
    total++; if (rb) begin bad++; $display("FAIL stall_cmd_ready got=1 while busy exp=0"); end
    total++; if (proto_err != pe0) begin bad++; $display("FAIL stall_stability got=%0d errs exp=0", proto_err - pe0); end
    total++; if (log_addr.size() - base < 2 || int'(log_ack_t[base+1] - log_req_t[base+1]) != 70) begin bad++;
      $display("FAIL stall_ack_delay txns=%0d exp ack 70 after req", log_addr.size() - base); end
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0 || log_addr.size() - base != 5) begin bad++;
      $display("FAIL stall_no_second busy=%b txns=%0d exp=0/5", busy, log_addr.size() - base); end
  endtask

  task automatic test_spurious();
    bit got, rb; logic [1:0] st; int base, r0;
    spur_req_cnt++;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || bus_req !== 1'b0 || cmd_ready !== 1'b1 || spur_done_cnt != spur_req_cnt) begin bad++;
      $display("FAIL spur_idle busy=%b req=%b ready=%b pulsed=%0d exp=0/0/1/%0d", busy, bus_req, cmd_ready, spur_done_cnt, spur_req_cnt); end
    set_csr(16'h0002, 16'h0004, 16'h0004, 16'h0004);
    base = log_addr.size(); r0 = reads_total;
    send_cmd(16'h0300, 16'h0500, 16'h0004, 0);
    repeat (3) @(negedge clk);
    spur_req_cnt++;
    wait_rsp(80, got, st, rb);
    total++; if (!got || st !== 2'd0) begin bad++; $display("FAIL spur_op_status got=%0d valid=%b exp=0", st, got); end
    total++; if (log_addr.size() - base != 6 || reads_total - r0 != 2) begin bad++;
      $display("FAIL spur_op_txns got=%0d reads=%0d exp=6/2", log_addr.size() - base, reads_total - r0); end
  endtask

  task automatic test_reset_mid_poll();
    bit got, rb, found, seen_rsp, seen_req; logic [1:0] st; int base, r0, lat;
    set_csr(16'h0002, 16'h0002, 16'h0002, 16'h0002);
    r0 = reads_total; found = 0;
    send_cmd(16'h0010, 16'h0020, 16'h0004, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reads_total != r0 && !bus_req) begin found = 1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL midpoll_reach no poll wait within 40 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus_req !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++;
      $display("FAIL midpoll_reset req=%b busy=%b ready=%b rsp=%b exp=0/0/1/0", bus_req, busy, cmd_ready, rsp_valid); end
    seen_rsp = 0; seen_req = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1;
      if (bus_req) seen_req = 1;
    end
    total++; if (seen_rsp || seen_req || reads_total - r0 != 1) begin bad++;
      $display("FAIL midpoll_quiet rsp=%b req=%b reads=%0d exp=0/0/1", seen_rsp, seen_req, reads_total - r0); end
    set_csr(16'h0004, 16'h0004, 16'h0004, 16'h0004);
    base = log_addr.size();
    send_cmd(16'h0200, 16'h0400, 16'h0008, 0);
    wait_rsp(60, got, st, rb);
    lat = int'(($time - t_cmd) / 10);
    total++; if (!got || st !== 2'd0 || lat != 16 || log_addr.size() - base != 5) begin bad++;
      $display("FAIL midpoll_recover status=%0d valid=%b lat=%0d txns=%0d exp=0/1/16/5", st, got, lat, log_addr.size() - base); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_size = '0; t_cmd = 0;
    for (int i = 0; i < 8; i++) csr_tab[i] = 16'h0004;
    test_reset();
    test_normal();
    test_error_priority();
    test_bad_args();
    test_timeout();
    test_stall_hold();
    test_spurious();
    test_reset_mid_poll();
    total++; if (proto_err != 0) begin bad++; $display("FAIL bus_protocol got=%0d violations exp=0", proto_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
